// File: rtl/ep2_vector_sweeper_pkg.sv
// Shared types and defaults for the ep2 exhaustive input sweeper.
// Imported by the sweeper top and its hold-window counter.
package ep2_sweep_pkg;

  localparam int N_IN_DEF = 4;
  localparam int HOLD_DEF = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } sweep_state_e;

endpackage

// File: rtl/ep2_vector_sweeper_if.sv
// Stimulus/capture bundle between the ep2 sweeper (slave) and whoever
// launches sweeps and models the function under test (master).
interface ep2_vector_sweeper_if #(
  parameter int N_IN = 4
);
  localparam int NV = 2**N_IN;

  logic            start;
  logic [NV-1:0]   expected;
  logic            s_in;
  logic [N_IN-1:0] vec;
  logic            busy;
  logic            done;
  logic            pass;
  logic [NV-1:0]   table_out;
  logic [NV-1:0]   fail_mask;

  modport master (
    output start, expected, s_in,
    input  vec, busy, done, pass, table_out, fail_mask
  );

  modport slave (
    input  start, expected, s_in,
    output vec, busy, done, pass, table_out, fail_mask
  );

endinterface

// File: rtl/ep2_vector_sweeper_hold.sv
// Hold-window timer for the ep2 sweeper: asserts last on the final clock
// of each HOLD_CYCLES-long window while enabled.
module sweep_hold_counter
  import ep2_sweep_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] cnt_r;

  // Window counter: cleared on sweep launch, wraps to zero after each sample clock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      if (cnt_r == CNT_LAST) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  assign last = en && (cnt_r == CNT_LAST);

endmodule

// File: rtl/ep2_vector_sweeper.sv
// Exhaustive input sweeper for the ep2 4-input function: walks every input
// vector, samples s_in once per vector and compares the table to expected.
module ep2_vector_sweeper
  import ep2_sweep_pkg::*;
#(
  parameter int N_IN        = N_IN_DEF,
  parameter int HOLD_CYCLES = HOLD_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  ep2_vector_sweeper_if.slave sw
);

  localparam int NV = 2**N_IN;
  localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};

  sweep_state_e    state_r;
  logic [N_IN-1:0] vec_r;
  logic            busy_r;
  logic            done_r;
  logic            pass_r;
  logic [NV-1:0]   table_r;
  logic [NV-1:0]   exp_r;
  logic [NV-1:0]   next_table_s;
  logic            launch_s;
  logic            hold_en_s;
  logic            hold_last_s;

  assign launch_s  = ((state_r == IDLE) || (state_r == DONE)) && sw.start;
  assign hold_en_s = (state_r == HOLD);

  sweep_hold_counter #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (launch_s),
    .en   (hold_en_s),
    .last (hold_last_s)
  );

  // Table as it will look after the current vector's sample lands; pass uses it directly.
  always_comb begin
    next_table_s        = table_r;
    next_table_s[vec_r] = sw.s_in;
  end

  // Sweep FSM with vector counter, table capture and result flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      vec_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
      table_r <= '0;
      exp_r   <= '0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (sw.start) begin
            vec_r   <= '0;
            table_r <= '0;
            exp_r   <= sw.expected;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= HOLD;
          end
        end
        HOLD: begin
          if (hold_last_s) begin
            table_r <= next_table_s;
            if (vec_r == VEC_LAST) begin
              state_r <= DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              pass_r  <= (next_table_s == exp_r);
            end else begin
              vec_r <= vec_r + N_IN'(1);
            end
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign sw.vec       = vec_r;
  assign sw.busy      = busy_r;
  assign sw.done      = done_r;
  assign sw.pass      = pass_r;
  assign sw.table_out = table_r;
  assign sw.fail_mask = table_r ^ exp_r;

endmodule
